// File: rtl/hd63701_sci.sv
// HD63701 serial communication interface: RMCR/TRCSR/RDR/TDR register window
// plus an 8N1 transmitter and receiver clocked by the CPU E-cycle enable.
module hd63701_sci #(
    parameter int unsigned SIM_DIV = 0
) (
    input  logic        CLKx2,
    input  logic        RST_N,
    input  logic        CE,
    input  logic [15:0] AD,
    input  logic        RW,
    input  logic [7:0]  DO,
    output logic [7:0]  RDATA,
    output logic        SEL,
    output logic        IRQ2_SCI,
    output logic        TXD,
    input  logic        RXD
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } sci_state_t;

    logic [3:0] rmcr;
    logic       rie, re, tie, te;
    logic       tdre, rdrf, orfe;
    logic [7:0] rdr, tdr;

    logic       tdre_next, rdrf_next, orfe_next;
    logic [7:0] rdr_next;

    logic       wr_rmcr, wr_trcsr, wr_tdr, rd_rdr;

    logic [12:0] base_period, period, half_period;

    sci_state_t tx_state, tx_state_next;
    logic [12:0] tx_cnt, tx_cnt_next;
    logic [2:0]  tx_bit, tx_bit_next;
    logic [7:0]  tx_shift, tx_shift_next;
    logic        tx_load;
    logic        tx_last;

    sci_state_t rx_state, rx_state_next;
    logic [12:0] rx_cnt, rx_cnt_next;
    logic [2:0]  rx_bit, rx_bit_next;
    logic [7:0]  rx_shift, rx_shift_next;
    logic        rx_done;
    logic        rx_last, rx_half;
    logic        rx_meta, rx_sync, rx_prev;

    assign SEL      = (AD[15:2] == 14'h0004);
    assign wr_rmcr  = CE && SEL && !RW && (AD[1:0] == 2'd0);
    assign wr_trcsr = CE && SEL && !RW && (AD[1:0] == 2'd1);
    assign wr_tdr   = CE && SEL && !RW && (AD[1:0] == 2'd3);
    assign rd_rdr   = CE && SEL &&  RW && (AD[1:0] == 2'd2);

    always_comb begin
        RDATA = 8'h00;
        if (SEL) begin
            case (AD[1:0])
                2'd0: RDATA = {4'b0000, rmcr};
                2'd1: RDATA = {rdrf, orfe, tdre, rie, re, tie, te, 1'b0};
                2'd2: RDATA = rdr;
                default: RDATA = tdr;
            endcase
        end
    end

    // Bit period never collapses to zero, even with an aggressive SIM_DIV.
    always_comb begin
        case (rmcr[1:0])
            2'b00:   base_period = 13'd16;
            2'b01:   base_period = 13'd128;
            2'b10:   base_period = 13'd1024;
            default: base_period = 13'd4096;
        endcase
        period = base_period >> SIM_DIV;
        if (period == 13'd0) begin
            period = 13'd1;
        end
        half_period = period >> 1;
        if (half_period == 13'd0) begin
            half_period = 13'd1;
        end
    end

    assign tx_last = (tx_cnt >= period - 13'd1);
    assign rx_last = (rx_cnt >= period - 13'd1);
    assign rx_half = (rx_cnt >= half_period - 13'd1);

    always_ff @(posedge CLKx2 or negedge RST_N) begin
        if (!RST_N) begin
            rmcr <= 4'h0;
            rie  <= 1'b0;
            re   <= 1'b0;
            tie  <= 1'b0;
            te   <= 1'b0;
            tdr  <= 8'h00;
        end else begin
            if (wr_rmcr) begin
                rmcr <= DO[3:0];
            end
            if (wr_trcsr) begin
                rie <= DO[4];
                re  <= DO[3];
                tie <= DO[2];
                te  <= DO[1];
            end
            if (wr_tdr) begin
                tdr <= DO;
            end
        end
    end

    always_ff @(posedge CLKx2 or negedge RST_N) begin
        if (!RST_N) begin
            tx_state <= S_IDLE;
            tx_cnt   <= 13'd0;
            tx_bit   <= 3'd0;
            tx_shift <= 8'h00;
        end else begin
            tx_state <= tx_state_next;
            tx_cnt   <= tx_cnt_next;
            tx_bit   <= tx_bit_next;
            tx_shift <= tx_shift_next;
        end
    end

    // A load reads the registered TDR, so a same-cycle TDR write stays pending.
    always_comb begin
        tx_state_next = tx_state;
        tx_cnt_next   = tx_cnt;
        tx_bit_next   = tx_bit;
        tx_shift_next = tx_shift;
        tx_load       = 1'b0;
        if (CE) begin
            case (tx_state)
                S_IDLE: begin
                    if (te && !tdre) begin
                        tx_load       = 1'b1;
                        tx_shift_next = tdr;
                        tx_cnt_next   = 13'd0;
                        tx_state_next = S_START;
                    end
                end
                S_START: begin
                    if (tx_last) begin
                        tx_cnt_next   = 13'd0;
                        tx_bit_next   = 3'd0;
                        tx_state_next = S_DATA;
                    end else begin
                        tx_cnt_next = tx_cnt + 13'd1;
                    end
                end
                S_DATA: begin
                    if (tx_last) begin
                        tx_cnt_next   = 13'd0;
                        tx_shift_next = {1'b1, tx_shift[7:1]};
                        if (tx_bit == 3'd7) begin
                            tx_state_next = S_STOP;
                        end else begin
                            tx_bit_next = tx_bit + 3'd1;
                        end
                    end else begin
                        tx_cnt_next = tx_cnt + 13'd1;
                    end
                end
                default: begin
                    if (tx_last) begin
                        tx_cnt_next = 13'd0;
                        if (te && !tdre) begin
                            tx_load       = 1'b1;
                            tx_shift_next = tdr;
                            tx_state_next = S_START;
                        end else begin
                            tx_state_next = S_IDLE;
                        end
                    end else begin
                        tx_cnt_next = tx_cnt + 13'd1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        TXD = 1'b1;
        if (tx_state == S_START) begin
            TXD = 1'b0;
        end else if (tx_state == S_DATA) begin
            TXD = tx_shift[0];
        end
    end

    always_ff @(posedge CLKx2 or negedge RST_N) begin
        if (!RST_N) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= RXD;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge CLKx2 or negedge RST_N) begin
        if (!RST_N) begin
            rx_state <= S_IDLE;
            rx_cnt   <= 13'd0;
            rx_bit   <= 3'd0;
            rx_shift <= 8'h00;
            rx_prev  <= 1'b1;
        end else begin
            rx_state <= rx_state_next;
            rx_cnt   <= rx_cnt_next;
            rx_bit   <= rx_bit_next;
            rx_shift <= rx_shift_next;
            if (CE) begin
                rx_prev <= rx_sync;
            end
        end
    end

    always_comb begin
        rx_state_next = rx_state;
        rx_cnt_next   = rx_cnt;
        rx_bit_next   = rx_bit;
        rx_shift_next = rx_shift;
        rx_done       = 1'b0;
        if (CE) begin
            if (!re) begin
                rx_state_next = S_IDLE;
                rx_cnt_next   = 13'd0;
            end else begin
                case (rx_state)
                    S_IDLE: begin
                        if (rx_prev && !rx_sync) begin
                            rx_cnt_next   = 13'd0;
                            rx_state_next = S_START;
                        end
                    end
                    S_START: begin
                        if (rx_half) begin
                            rx_cnt_next   = 13'd0;
                            rx_bit_next   = 3'd0;
                            rx_state_next = rx_sync ? S_IDLE : S_DATA;
                        end else begin
                            rx_cnt_next = rx_cnt + 13'd1;
                        end
                    end
                    S_DATA: begin
                        if (rx_last) begin
                            rx_cnt_next   = 13'd0;
                            rx_shift_next = {rx_sync, rx_shift[7:1]};
                            if (rx_bit == 3'd7) begin
                                rx_state_next = S_STOP;
                            end else begin
                                rx_bit_next = rx_bit + 3'd1;
                            end
                        end else begin
                            rx_cnt_next = rx_cnt + 13'd1;
                        end
                    end
                    default: begin
                        if (rx_last) begin
                            rx_cnt_next   = 13'd0;
                            rx_done       = 1'b1;
                            rx_state_next = S_IDLE;
                        end else begin
                            rx_cnt_next = rx_cnt + 13'd1;
                        end
                    end
                endcase
            end
        end
    end

    // A completing byte outranks a same-cycle RDR read: the read clears first,
    // so the new byte lands as a clean reception rather than an overrun.
    always_comb begin
        tdre_next = tdre;
        if (wr_tdr) begin
            tdre_next = 1'b0;
        end else if (tx_load) begin
            tdre_next = 1'b1;
        end
        rdrf_next = rd_rdr ? 1'b0 : rdrf;
        orfe_next = rd_rdr ? 1'b0 : orfe;
        rdr_next  = rdr;
        if (rx_done) begin
            if (rx_sync) begin
                if (!rdrf || rd_rdr) begin
                    rdr_next  = rx_shift;
                    rdrf_next = 1'b1;
                end else begin
                    orfe_next = 1'b1;
                end
            end else begin
                orfe_next = 1'b1;
                rdr_next  = rx_shift;
            end
        end
    end

    always_ff @(posedge CLKx2 or negedge RST_N) begin
        if (!RST_N) begin
            tdre <= 1'b1;
            rdrf <= 1'b0;
            orfe <= 1'b0;
            rdr  <= 8'h00;
        end else begin
            tdre <= tdre_next;
            rdrf <= rdrf_next;
            orfe <= orfe_next;
            rdr  <= rdr_next;
        end
    end

    always_ff @(posedge CLKx2 or negedge RST_N) begin
        if (!RST_N) begin
            IRQ2_SCI <= 1'b0;
        end else begin
            IRQ2_SCI <= (rie & (rdrf | orfe)) | (tie & tdre);
        end
    end

endmodule

// File: tb/tb_hd63701_sci.sv
// Scoreboard bench for hd63701_sci: register reads and decoded TXD frames are
// compared against expectations queued by the stimulus and a flag-level model.
module tb_hd63701_sci;

    logic        CLKx2;
    logic        RST_N;
    logic        CE;
    logic [15:0] AD;
    logic        RW;
    logic [7:0]  DO;
    logic [7:0]  RDATA;
    logic        SEL;
    logic        IRQ2_SCI;
    logic        TXD;
    logic        RXD;

    hd63701_sci #(.SIM_DIV(0)) dut (
        .CLKx2    (CLKx2),
        .RST_N    (RST_N),
        .CE       (CE),
        .AD       (AD),
        .RW       (RW),
        .DO       (DO),
        .RDATA    (RDATA),
        .SEL      (SEL),
        .IRQ2_SCI (IRQ2_SCI),
        .TXD      (TXD),
        .RXD      (RXD)
    );

    int tests = 0;
    int fails = 0;
    int ce_count = 0;
    int tx_n = 16;
    int frame_e0 = 0;
    bit tx_mon_en = 1'b1;
    bit rd_strobe = 1'b0;
    event frame_started;

    logic [7:0] rd_q[$];
    string      rd_name_q[$];
    logic [7:0] tx_q[$];

    logic m_rdrf, m_orfe, m_tdre, m_rie, m_re, m_tie, m_te;
    logic [7:0] m_rdr;

    initial begin
        CLKx2 = 1'b0;
        forever #5 CLKx2 = ~CLKx2;
    end

    // CE is high across every second rising edge.
    initial begin
        CE = 1'b0;
        forever begin
            @(posedge CLKx2);
            #2 CE = ~CE;
        end
    end

    always @(posedge CLKx2) begin
        if (CE) ce_count <= ce_count + 1;
    end

    task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %02h expected %02h", name, got, exp);
        end
    endtask

    function automatic int period_of(input logic [1:0] r);
        case (r)
            2'b00:   return 16;
            2'b01:   return 128;
            2'b10:   return 1024;
            default: return 4096;
        endcase
    endfunction

    function automatic logic [7:0] trcsr_model();
        return {m_rdrf, m_orfe, m_tdre, m_rie, m_re, m_tie, m_te, 1'b0};
    endfunction

    function automatic logic irq_model();
        return (m_rie & (m_rdrf | m_orfe)) | (m_tie & m_tdre);
    endfunction

    task automatic model_reset();
        m_rdrf = 0; m_orfe = 0; m_tdre = 1; m_rie = 0; m_re = 0; m_tie = 0; m_te = 0;
        m_rdr = 8'h00;
    endtask

    task automatic model_frame(input logic [7:0] d, input logic stop_bit);
        if (stop_bit) begin
            if (!m_rdrf) begin
                m_rdr = d;
                m_rdrf = 1;
            end else begin
                m_orfe = 1;
            end
        end else begin
            m_orfe = 1;
            m_rdr = d;
        end
    endtask

    task automatic wait_ce();
        @(posedge CLKx2 iff CE);
        #3;
    endtask

    task automatic applyStimulus_write(input logic [15:0] a, input logic [7:0] d);
        @(posedge CLKx2 iff CE);
        #3 AD = a; RW = 1'b0; DO = d;
        @(posedge CLKx2 iff CE);
        #3 AD = 16'hFFFF; RW = 1'b1;
    endtask

    task automatic write_trcsr(input logic [7:0] v);
        applyStimulus_write(16'h0011, v);
        m_rie = v[4]; m_re = v[3]; m_tie = v[2]; m_te = v[1];
    endtask

    task automatic bus_read(input logic [15:0] a, input string name, input logic [7:0] exp);
        @(posedge CLKx2 iff CE);
        #3 AD = a; RW = 1'b1; rd_strobe = 1'b1;
        rd_q.push_back(exp);
        rd_name_q.push_back(name);
        @(posedge CLKx2 iff CE);
        #3 AD = 16'hFFFF; rd_strobe = 1'b0;
    endtask

    task automatic read_rdr(input string name);
        bus_read(16'h0012, name, m_rdr);
        m_rdrf = 0;
        m_orfe = 0;
    endtask

    task automatic checkOutput_irq(input string name);
        wait_ce();
        check8(name, IRQ2_SCI, irq_model());
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int n);
        @(posedge CLKx2 iff CE);
        #3 frame_e0 = ce_count;
        RXD = 1'b0;
        -> frame_started;
        for (int j = 0; j < 8; j++) begin
            repeat (n) @(posedge CLKx2 iff CE);
            #3 RXD = d[j];
        end
        repeat (n) @(posedge CLKx2 iff CE);
        #3 RXD = stop_bit;
        repeat (n) @(posedge CLKx2 iff CE);
        #3 RXD = 1'b1;
        repeat (3) wait_ce();
    endtask

    task automatic wait_tx_done(input int budget);
        int k = 0;
        while (tx_q.size() != 0 && k < budget) begin
            wait_ce();
            k++;
        end
        check8("tx_timeout", {7'b0, tx_q.size() != 0}, 8'h00);
    endtask

    // Read monitor: the negedge before the committing edge sees the pre-edge value.
    always @(negedge CLKx2) begin
        if (CE && rd_strobe) begin
            if (rd_q.size() == 0) begin
                check8("read_queue_underflow", 8'h01, 8'h00);
            end else begin
                check8(rd_name_q.pop_front(), RDATA, rd_q.pop_front());
            end
        end
    end

    // TX monitor: rebuilds each frame from TXD and checks every bit's width.
    initial begin
        logic [9:0] frm;
        logic       bad_width;
        logic [7:0] exp;
        forever begin
            @(posedge CLKx2 iff CE);
            #1;
            if (tx_mon_en && TXD === 1'b0) begin
                bad_width = 1'b0;
                for (int b = 0; b < 10; b++) begin
                    if (b > 0) begin
                        @(posedge CLKx2 iff CE);
                        #1;
                    end
                    frm[b] = TXD;
                    for (int k = 1; k < tx_n; k++) begin
                        @(posedge CLKx2 iff CE);
                        #1;
                        if (TXD !== frm[b]) bad_width = 1'b1;
                    end
                end
                if (tx_q.size() == 0) begin
                    check8("tx_unexpected_frame", frm[8:1], 8'hXX);
                end else begin
                    exp = tx_q.pop_front();
                    check8("tx_frame_data", frm[8:1], exp);
                    check8("tx_start_stop", {6'b0, frm[9], frm[0]}, 8'h02);
                    check8("tx_bit_width", {7'b0, bad_width}, 8'h00);
                end
            end
        end
    end

    initial begin
        logic [15:0] sel_addrs [8];
        logic [7:0]  d;
        logic        stop_bit;
        logic        rie_r, tie_r;
        int          half;

        sel_addrs = '{16'h000F, 16'h0010, 16'h0011, 16'h0012,
                      16'h0013, 16'h0014, 16'h1010, 16'h8011};
        RST_N = 1'b0; AD = 16'hFFFF; RW = 1'b1; DO = 8'h00; RXD = 1'b1;
        model_reset();
        repeat (3) @(posedge CLKx2);
        #3;
        check8("reset_txd", TXD, 1'b1);
        check8("reset_irq", IRQ2_SCI, 1'b0);
        for (int i = 0; i < 8; i++) begin
            AD = sel_addrs[i];
            #1;
            check8($sformatf("sel_%04h", sel_addrs[i]), SEL,
                   (sel_addrs[i] >= 16'h0010 && sel_addrs[i] <= 16'h0013));
            if (!(sel_addrs[i] >= 16'h0010 && sel_addrs[i] <= 16'h0013))
                check8($sformatf("rdata_unsel_%04h", sel_addrs[i]), RDATA, 8'h00);
        end
        AD = 16'h0011;
        #1 check8("reset_trcsr_comb", RDATA, 8'h20);
        AD = 16'hFFFF;
        @(posedge CLKx2);
        #3 RST_N = 1'b1;

        bus_read(16'h0011, "trcsr_after_reset", trcsr_model());
        write_trcsr(8'h04);
        checkOutput_irq("irq_tie_tdre");

        // Transmit $A5 at N = 16, then a back-to-back pair, then random bytes.
        applyStimulus_write(16'h0010, 8'h00);
        tx_n = period_of(2'b00);
        write_trcsr(8'h02);
        checkOutput_irq("irq_tie_off");
        tx_q.push_back(8'hA5);
        applyStimulus_write(16'h0013, 8'hA5);
        bus_read(16'h0011, "trcsr_tdre_reload", 8'h22);
        wait_tx_done(2000);

        tx_q.push_back(8'h3C);
        tx_q.push_back(8'hC3);
        applyStimulus_write(16'h0013, 8'h3C);
        applyStimulus_write(16'h0013, 8'hC3);
        wait_tx_done(4000);

        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom);
            tx_q.push_back(d);
            applyStimulus_write(16'h0013, d);
            wait_tx_done(2000);
        end

        // TE cleared mid-frame: the frame completes and a later write stays pending.
        tx_q.push_back(8'h96);
        applyStimulus_write(16'h0013, 8'h96);
        repeat (30) wait_ce();
        write_trcsr(8'h00);
        wait_tx_done(2000);
        applyStimulus_write(16'h0013, 8'h5A);
        m_tdre = 0;
        repeat (200) wait_ce();
        bus_read(16'h0011, "trcsr_tdr_pending", trcsr_model());

        // Reception at N = 128 with RIE.
        applyStimulus_write(16'h0010, 8'h01);
        write_trcsr(8'h18);
        send_frame(8'h3C, 1'b1, period_of(2'b01));
        model_frame(8'h3C, 1'b1);
        checkOutput_irq("irq_rx_full");
        bus_read(16'h0011, "trcsr_rx_full", trcsr_model());
        read_rdr("rdr_3c");
        checkOutput_irq("irq_rx_cleared");

        // Overrun, framing error and glitch rejection at N = 16.
        applyStimulus_write(16'h0010, 8'h00);
        write_trcsr(8'h08);
        send_frame(8'h11, 1'b1, 16);
        model_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1, 16);
        model_frame(8'h22, 1'b1);
        bus_read(16'h0011, "trcsr_overrun", trcsr_model());
        read_rdr("rdr_overrun");
        bus_read(16'h0011, "trcsr_overrun_cleared", trcsr_model());

        send_frame(8'h55, 1'b0, 16);
        model_frame(8'h55, 1'b0);
        bus_read(16'h0011, "trcsr_framing", trcsr_model());
        read_rdr("rdr_framing");

        @(posedge CLKx2 iff CE);
        #3 RXD = 1'b0;
        repeat (4) @(posedge CLKx2 iff CE);
        #3 RXD = 1'b1;
        repeat (200) wait_ce();
        bus_read(16'h0011, "trcsr_glitch", trcsr_model());
        bus_read(16'h0012, "rdr_glitch", m_rdr);

        // RDR read colliding with the completion edge of the next byte.
        send_frame(8'hE7, 1'b1, 16);
        model_frame(8'hE7, 1'b1);
        half = 16 / 2;
        fork
            send_frame(8'h3A, 1'b1, 16);
            begin
                @(frame_started);
                do begin
                    @(posedge CLKx2 iff CE);
                    #3;
                end while (ce_count < frame_e0 + 2 + half + 9 * 16 - 1);
                AD = 16'h0012; RW = 1'b1; rd_strobe = 1'b1;
                rd_q.push_back(m_rdr);
                rd_name_q.push_back("rdr_conflict_old");
                @(posedge CLKx2 iff CE);
                #3 AD = 16'hFFFF; rd_strobe = 1'b0;
            end
        join
        m_rdr = 8'h3A; m_rdrf = 1; m_orfe = 0;
        bus_read(16'h0011, "trcsr_conflict", trcsr_model());
        read_rdr("rdr_conflict_new");

        // Clearing RE mid-frame drops the byte without touching flags.
        fork
            send_frame(8'hC3, 1'b1, 16);
            begin
                repeat (40) wait_ce();
                write_trcsr(8'h00);
            end
        join
        write_trcsr(8'h08);
        bus_read(16'h0011, "trcsr_re_abort", trcsr_model());
        bus_read(16'h0012, "rdr_re_abort", m_rdr);

        for (int i = 0; i < 8; i++) begin
            rie_r = 1'($urandom);
            tie_r = 1'($urandom);
            write_trcsr({3'b000, rie_r, 1'b1, tie_r, 2'b00});
            d = 8'($urandom);
            stop_bit = ($urandom_range(0, 3) != 0);
            send_frame(d, stop_bit, 16);
            model_frame(d, stop_bit);
            checkOutput_irq($sformatf("irq_rand_%0d", i));
            case ($urandom_range(0, 2))
                0: read_rdr($sformatf("rdr_rand_%0d", i));
                1: bus_read(16'h0011, $sformatf("trcsr_rand_%0d", i), trcsr_model());
                default: ;
            endcase
            checkOutput_irq($sformatf("irq_rand_post_%0d", i));
        end

        // Reset in the middle of the pending frame.
        tx_mon_en = 1'b0;
        write_trcsr(8'h02);
        repeat (40) wait_ce();
        check8("tx_midframe_active", {7'b0, dut.tx_state != 2'd0}, 8'h01);
        @(negedge CLKx2);
        RST_N = 1'b0;
        #1;
        model_reset();
        check8("reset_midframe_txd", TXD, 1'b1);
        AD = 16'h0011;
        #1 check8("reset_midframe_trcsr", RDATA, 8'h20);
        AD = 16'hFFFF;
        @(posedge CLKx2);
        #3 RST_N = 1'b1;
        bus_read(16'h0011, "trcsr_after_midframe_reset", trcsr_model());
        checkOutput_irq("irq_after_midframe_reset");
        repeat (5) wait_ce();

        check8("read_queue_drained", 8'(rd_q.size()), 8'h00);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hd63701_sci.md
Name: hd63701_sci

Overview:
- Serial Communication Interface (SCI) for the HD63701 core: a bus responder at the on-chip register window, answering the core's AD/RW/DO bus cycles and returning read data to the core's DI mux.
- Implements an 8N1 asynchronous UART: TXD toward the host link, RXD from it.
- Drives IRQ2_SCI into the core's sequencer.
- Register subset: RMCR $0010, TRCSR $0011, RDR $0012, TDR $0013.

Parameters:
- SIM_DIV, 0, right-shift applied to the bit-period count for fast simulation (0 = real timing).

Ports:
- CLKx2  in  1  system clock, same clock as the core.
- RST_N  in  1  reset, asynchronous, active-low.
- CE  in  1  one-cycle pulse per CPU E cycle (bus cycle); all state advances only when CE=1.
- AD  in  16  CPU address.
- RW  in  1  CPU read/write: 1 = read, 0 = write.
- DO  in  8  CPU write data.
- RDATA  out  8  read data to the core's DI mux.
- SEL  out  1  high when AD is in $0010..$0013; combinational.
- IRQ2_SCI  out  1  interrupt request; level, active-high.
- TXD  out  1  serial transmit line; idle high.
- RXD  in  1  serial receive line; asynchronous input.

Behaviour:
- Reset values:
  - RMCR = 0; TRCSR = $20 (TDRE=1, all other bits 0); RDR = 0; TDR = 0.
  - TXD = 1, IRQ2_SCI = 0, RDATA = 0.
  - Both state machines in IDLE.
  - Reset mid-frame aborts immediately; TXD returns to 1 asynchronously.
- Address decode:
  - SEL = (AD[15:2] == $0004).
  - Write commits on CE && SEL && !RW.
  - Read side effects occur on CE && SEL && RW.
- RDATA:
  - Combinational mux of the selected register; 0 when SEL=0.
  - RMCR reads {4'b0, RMCR[3:0]}.
  - TRCSR reads {RDRF, ORFE, TDRE, RIE, RE, TIE, TE, 1'b0}.
- Writes:
  - RMCR stores DO[3:0].
  - TRCSR stores DO[4:1] only; status bits and WU are read-only, and WU is ignored.
  - TDR stores DO and clears TDRE.
  - RDR writes are ignored.
- Bit period N, in CE cycles, is set by RMCR[1:0]: 00 = 16, 01 = 128, 10 = 1024, 11 = 4096. N is then right-shifted by SIM_DIV. RMCR[3:2] (clock control) is stored but has no effect; the internal clock is always used.
- TX FSM: IDLE -> START -> DATA(8) -> STOP -> IDLE.
  - IDLE: if TE=1 and TDRE=0, copy TDR to the shifter, set TDRE=1 in the same CE, and enter START.
  - Each state holds TXD for N CE cycles.
  - START drives TXD=0. DATA shifts LSB first. STOP drives TXD=1.
  - From STOP, the next frame starts back-to-back if TDRE=0 and TE=1.
  - Clearing TE mid-frame completes the current frame, then idles.
- RX FSM: IDLE -> START -> DATA(8) -> STOP -> IDLE.
  - RXD passes through a 2-flop synchronizer before use.
  - IDLE: if RE=1 and a 1->0 edge is seen on the synchronized RXD, enter START.
  - START: wait N/2 CE cycles, then sample. If RXD=1 (false start), return to IDLE.
  - DATA: sample every N CE cycles, LSB first.
  - STOP: sample after N CE cycles.
    - Stop=1 and RDRF=0: RDR <= data, RDRF <= 1.
    - Stop=1 and RDRF=1: ORFE <= 1 (overrun); RDR is unchanged.
    - Stop=0: ORFE <= 1 (framing error); RDR <= data; RDRF is unchanged.
  - Clearing RE aborts the frame and returns to IDLE; no flags are updated.
- RDR read clears RDRF and ORFE in that CE.
- Same-CE conflict, RDR read vs. new byte completion: the completion wins. RDR takes the new data, RDRF stays 1, ORFE is not set.
- Same-CE conflict, TDR write vs. TX load: the TX load takes the old TDR value, and the written value stays pending with TDRE=0.
- IRQ2_SCI = (RIE & (RDRF | ORFE)) | (TIE & TDRE), registered; it updates 1 CLKx2 after the flag change.
- When CE=0, nothing changes except the RXD synchronizer and the asynchronous reset.

Test Plan:
- Reset -> read $0011 = $20, TXD = 1, IRQ2_SCI = 0, SEL = 1 only for AD $0010..$0013.
- RMCR = 0, TRCSR = $02, write TDR = $A5 -> TDRE = 1 on the next CE; TXD carries 0,1,0,1,0,0,1,0,1,1 (start bit, $A5 LSB first, stop bit), each bit exactly 16 CE cycles.
- Reception:
  - Step 1: RE = 1, RIE = 1; drive $3C on RXD at N = 128 -> RDRF = 1, IRQ2_SCI = 1, read $0012 = $3C.
  - Step 2: the RDR read clears RDRF -> IRQ2_SCI = 0.
- Receive two bytes ($11, $22) without reading -> RDR = $11, ORFE = 1, TRCSR reads $C8; a read of $0012 clears both RDRF and ORFE.
- Stop bit forced to 0 on $55 -> ORFE = 1, RDRF = 0, RDR = $55.
- A 4-CE low glitch on RXD at N = 16 -> no reception, flags unchanged.
- RDR read in the same CE as a new byte's completion -> RDRF stays 1 with the new data and ORFE = 0.
- RST_N asserted mid-frame -> TXD = 1 immediately, TRCSR = $20.
